// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: decode inputs and datapath control outputs of the multicycle MIPS control unit
interface mc_control_fsm_if #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
);
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] funct;
    logic            zero;
    logic            PCen;
    logic            IorD;
    logic            MemWrite;
    logic            IRWrite;
    logic            RegDst;
    logic            MemtoReg;
    logic            RegWrite;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [2:0]      ALUControl;
    logic            PCsrc;
    logic            Ori;
    logic            illegal_o;
    logic [ST_W-1:0] state_o;
    modport master (
        input  op, funct, zero,
        output PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc, Ori, illegal_o, state_o
    );
    modport slave (
        output op, funct, zero,
        input  PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCsrc, Ori, illegal_o, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit sequencing the shared-memory datapath
module mc_control_fsm #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input logic              clk,
    input logic              reset,
    mc_control_fsm_if.master bus
);
    typedef enum logic [ST_W-1:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
        S_ALUWB, S_BRANCH, S_ADDI_EX, S_ORI_EX, S_GPI_EX, S_IMM_WB, S_JUMP
    } state_t;
    localparam logic [OP_W-1:0] OP_R    = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'('h2B);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_J    = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_GPI  = OP_W'('h1F);
    localparam logic [OP_W-1:0] F_ADD   = OP_W'('h20);
    localparam logic [OP_W-1:0] F_SUB   = OP_W'('h22);
    localparam logic [OP_W-1:0] F_AND   = OP_W'('h24);
    localparam logic [OP_W-1:0] F_OR    = OP_W'('h25);
    localparam logic [OP_W-1:0] F_SLT   = OP_W'('h2A);
    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       pc_write, branch, funct_ok;
    logic [2:0] alu_r;
    assign funct_ok = bus.funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign alu_r = bus.funct == F_SUB ? 3'b110 :
                   bus.funct == F_AND ? 3'b000 :
                   bus.funct == F_OR  ? 3'b001 :
                   bus.funct == F_SLT ? 3'b111 : 3'b010;
    // DECODE falling back to FETCH is exactly the unsupported-instruction case
    assign illegal_d = illegal_q | (state_q == S_DECODE && state_d == S_FETCH);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    always_comb begin
        state_d        = S_FETCH;
        pc_write       = 1'b0;
        branch         = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b010;
        bus.PCsrc      = 1'b0;
        bus.Ori        = 1'b0;
        case (state_q)
            S_RST: bus.ALUControl = 3'b000;
            S_FETCH: begin
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
                pc_write    = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_ok ? S_EXEC_R : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_GPI:       state_d = S_GPI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = bus.op == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.IorD = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = alu_r;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 3'b110;
                bus.PCsrc      = 1'b1;
                branch         = 1'b1;
            end
            S_ADDI_EX, S_ORI_EX, S_GPI_EX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = state_q == S_ORI_EX ? 3'b001 : 3'b010;
                bus.Ori        = state_q == S_GPI_EX;
                state_d        = S_IMM_WB;
            end
            S_IMM_WB: bus.RegWrite = 1'b1;
            S_JUMP: begin
                bus.ALUControl = 3'b011;
                pc_write       = 1'b1;
            end
            default: ;
        endcase
    end
    assign bus.PCen      = pc_write | (branch & bus.zero);
    assign bus.illegal_o = illegal_q;
    assign bus.state_o   = state_q;
endmodule
